multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath. It sequences one shared ALU, one unified instruction/data memory and the register file across per-instruction states.
- Decodes opcode/funct into datapath selects, and handshakes with memory via mem_ready.
- Detects illegal instructions and memory timeouts, then halts.

---
 rtl/multicycle_control_if.sv | 39 +++
 rtl/multicycle_control.sv | 278 +++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller side is the master; the datapath side is the slave.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       imm_zero_ext;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic [1:0] fault;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write,
        output reg_dst, mem_to_reg, reg_write,
        output alu_src_a, alu_src_b, alu_op, imm_zero_ext,
        output pc_source, state, fault
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write,
        input  reg_dst, mem_to_reg, reg_write,
        input  alu_src_a, alu_src_b, alu_op, imm_zero_ext,
        input  pc_source, state, fault
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch,
// decode, memory, ALU and writeback; halts on illegal op or mem timeout.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        EXEC_I    = 4'd9,
        IMM_WB    = 4'd10,
        JUMP      = 4'd11,
        HALT      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] F_NONE  = 2'b00;
    localparam logic [1:0] F_OP    = 2'b01;
    localparam logic [1:0] F_FUNCT = 2'b10;
    localparam logic [1:0] F_TMO   = 2'b11;

    localparam int CW  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam bit TMO_EN = (MEM_TIMEOUT != 0);

    state_t          state_q, state_d;
    logic [1:0]      fault_q, fault_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      op_q, fn_q;

    logic            pc_write, pc_write_cond;
    logic            iord, mem_read, mem_write, ir_write;
    logic            reg_dst, mem_to_reg, reg_write;
    logic            alu_src_a, imm_zero_ext;
    logic [1:0]      alu_src_b, pc_source;
    logic [2:0]      alu_op;
    logic            timeout;
    logic            is_mem, is_imm;

    function automatic logic funct_ok(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 ||
               f == 6'b100100 || f == 6'b100101 ||
               f == 6'b100111 || f == 6'b101010;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        logic [2:0] r;
        r = ALU_ADD;
        case (f)
            6'b100010: r = ALU_SUB;
            6'b100100: r = ALU_AND;
            6'b100101: r = ALU_OR;
            6'b100111: r = ALU_NOR;
            6'b101010: r = ALU_SLT;
            default:   r = ALU_ADD;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            fault_q <= F_NONE;
            cnt_q   <= '0;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            if (state_q == DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
        end
    end

    // Limit is hit only when this cycle is also a non-ready wait cycle,
    // so a ready response on the last allowed cycle still completes.
    assign timeout = TMO_EN && !bus.mem_ready && (cnt_q == CW'(LIM));
    assign is_mem  = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);
    assign is_imm  = (bus.opcode == OP_ADDI) || (bus.opcode == OP_ANDI) ||
                     (bus.opcode == OP_ORI);

    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        cnt_d         = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        imm_zero_ext  = 1'b0;
        pc_source     = 2'b00;

        unique case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout) begin
                    state_d = HALT;
                    fault_d = F_TMO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                unique case (1'b1)
                    is_mem:                 state_d = MEM_ADDR;
                    (bus.opcode == OP_R): begin
                        if (funct_ok(bus.funct)) begin
                            state_d = EXECUTE;
                        end else begin
                            state_d = HALT;
                            fault_d = F_FUNCT;
                        end
                    end
                    (bus.opcode == OP_BEQ): state_d = BRANCH;
                    is_imm:                 state_d = EXEC_I;
                    (bus.opcode == OP_J):   state_d = JUMP;
                    default: begin
                        state_d = HALT;
                        fault_d = F_OP;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEM_WB;
                end else if (timeout) begin
                    state_d = HALT;
                    fault_d = F_TMO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = HALT;
                    fault_d = F_TMO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu(fn_q);
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_d       = FETCH;
            end
            EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_op       = (op_q == OP_ANDI) ? ALU_AND :
                               (op_q == OP_ORI)  ? ALU_OR  : ALU_ADD;
                imm_zero_ext = (op_q == OP_ANDI) || (op_q == OP_ORI);
                state_d      = IMM_WB;
            end
            IMM_WB: begin
                reg_write    = 1'b1;
                imm_zero_ext = (op_q == OP_ANDI) || (op_q == OP_ORI);
                state_d      = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase

        // Nothing may reach the datapath while reset is held.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = ALU_ADD;
            imm_zero_ext  = 1'b0;
            pc_source     = 2'b00;
        end
    end

    assign bus.pc_en        = pc_write | (pc_write_cond & bus.zero);
    assign bus.iord         = iord;
    assign bus.mem_read     = mem_read;
    assign bus.mem_write    = mem_write;
    assign bus.ir_write     = ir_write;
    assign bus.reg_dst      = reg_dst;
    assign bus.mem_to_reg   = mem_to_reg;
    assign bus.reg_write    = reg_write;
    assign bus.alu_src_a    = alu_src_a;
    assign bus.alu_src_b    = alu_src_b;
    assign bus.alu_op       = alu_op;
    assign bus.imm_zero_ext = imm_zero_ext;
    assign bus.pc_source    = pc_source;
    assign bus.state        = state_q;
    assign bus.fault        = fault_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed cycle-by-cycle checks of the multicycle MIPS control FSM.
// Runs with a short memory timeout so the wait limit is reachable.
module tb_multicycle_control;

    logic clk;
    logic reset;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [1:0]  flt;
        logic [16:0] ctl;
        string       name;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [16:0] act_ctl;
    assign act_ctl = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write,
                      bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                      bus.alu_op, bus.imm_zero_ext, bus.pc_source};

    function automatic logic [16:0] c(
        input logic pe, io, mr, mw, irw, rd, m2r, rw, sa,
        input logic [1:0] sb, input logic [2:0] aop,
        input logic ize, input logic [1:0] ps);
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ize, ps};
    endfunction

    function automatic vec_t mk(
        input logic r, input logic [5:0] op, fn, input logic z, rdy,
        input logic [3:0] st, input logic [1:0] flt,
        input logic [16:0] ctl, input string name);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy;
        v.st = st; v.flt = flt; v.ctl = ctl; v.name = name;
        return v;
    endfunction

    // Apply one cycle of inputs, check outputs mid-cycle, advance a cycle.
    task automatic step(input vec_t v);
        reset         = v.rst;
        bus.opcode    = v.op;
        bus.funct     = v.fn;
        bus.zero      = v.zero;
        bus.mem_ready = v.rdy;
        #1;
        checks++;
        if (bus.state !== v.st || bus.fault !== v.flt ||
            act_ctl !== v.ctl) begin
            errors++;
            $display("FAIL %s: st=%0d flt=%0d ctl=%b want st=%0d flt=%0d ctl=%b",
                     v.name, bus.state, bus.fault, act_ctl,
                     v.st, v.flt, v.ctl);
        end
        @(negedge clk);
    endtask

    localparam logic [5:0] R   = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] ANI = 6'b001100;
    localparam logic [5:0] ORI = 6'b001101;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] NOR = 6'b100111;
    localparam logic [5:0] ADD = 6'b100000;

    logic [16:0] z0, fg, fw, dec, exn, exa, awb, mad, mrd, mwb;
    logic [16:0] br1, br0, ean, eiz, ead, iw, eor, mwr, jmp;
    vec_t tbl[$];

    initial begin
        z0  = '0;
        fg  = c(1,0,1,0,1,0,0,0,0,2'b01,3'b000,0,2'b00);
        fw  = c(0,0,1,0,0,0,0,0,0,2'b01,3'b000,0,2'b00);
        dec = c(0,0,0,0,0,0,0,0,0,2'b11,3'b000,0,2'b00);
        exn = c(0,0,0,0,0,0,0,0,1,2'b00,3'b100,0,2'b00);
        exa = c(0,0,0,0,0,0,0,0,1,2'b00,3'b000,0,2'b00);
        awb = c(0,0,0,0,0,1,0,1,0,2'b00,3'b000,0,2'b00);
        mad = c(0,0,0,0,0,0,0,0,1,2'b10,3'b000,0,2'b00);
        mrd = c(0,1,1,0,0,0,0,0,0,2'b00,3'b000,0,2'b00);
        mwb = c(0,0,0,0,0,0,1,1,0,2'b00,3'b000,0,2'b00);
        br1 = c(1,0,0,0,0,0,0,0,1,2'b00,3'b001,0,2'b01);
        br0 = c(0,0,0,0,0,0,0,0,1,2'b00,3'b001,0,2'b01);
        ean = c(0,0,0,0,0,0,0,0,1,2'b10,3'b010,1,2'b00);
        eiz = c(0,0,0,0,0,0,0,1,0,2'b00,3'b000,1,2'b00);
        ead = c(0,0,0,0,0,0,0,0,1,2'b10,3'b000,0,2'b00);
        iw  = c(0,0,0,0,0,0,0,1,0,2'b00,3'b000,0,2'b00);
        eor = c(0,0,0,0,0,0,0,0,1,2'b10,3'b011,1,2'b00);
        mwr = c(0,1,0,1,0,0,0,0,0,2'b00,3'b000,0,2'b00);
        jmp = c(1,0,0,0,0,0,0,0,0,2'b00,3'b000,0,2'b10);

        reset = 1'b1;
        bus.opcode = '0; bus.funct = '0;
        bus.zero = 1'b0; bus.mem_ready = 1'b1;

        // Main table: consecutive cycles through a small program.
        tbl.push_back(mk(1,R,NOR,0,1, 0,0,z0,  "reset"));
        tbl.push_back(mk(0,R,NOR,0,1, 0,0,fg,  "nor fetch"));
        tbl.push_back(mk(0,R,NOR,0,1, 1,0,dec, "nor decode"));
        tbl.push_back(mk(0,R,NOR,0,1, 6,0,exn, "nor execute"));
        tbl.push_back(mk(0,R,NOR,0,1, 7,0,awb, "nor alu_wb"));
        tbl.push_back(mk(0,LW,0,0,1,  0,0,fg,  "lw fetch"));
        tbl.push_back(mk(0,LW,0,0,0,  1,0,dec, "lw decode rdy ignored"));
        tbl.push_back(mk(0,LW,0,0,1,  2,0,mad, "lw mem_addr"));
        tbl.push_back(mk(0,LW,0,0,0,  3,0,mrd, "lw wait 1"));
        tbl.push_back(mk(0,LW,0,0,0,  3,0,mrd, "lw wait 2"));
        tbl.push_back(mk(0,LW,0,0,0,  3,0,mrd, "lw wait 3"));
        tbl.push_back(mk(0,LW,0,0,1,  3,0,mrd, "lw ready at limit"));
        tbl.push_back(mk(0,LW,0,0,1,  4,0,mwb, "lw mem_wb"));
        tbl.push_back(mk(0,BEQ,0,1,1, 0,0,fg,  "beq1 fetch"));
        tbl.push_back(mk(0,BEQ,0,1,1, 1,0,dec, "beq1 decode"));
        tbl.push_back(mk(0,BEQ,0,1,1, 8,0,br1, "beq taken"));
        tbl.push_back(mk(0,BEQ,0,0,1, 0,0,fg,  "beq0 fetch"));
        tbl.push_back(mk(0,BEQ,0,0,1, 1,0,dec, "beq0 decode"));
        tbl.push_back(mk(0,BEQ,0,0,1, 8,0,br0, "beq not taken"));
        tbl.push_back(mk(0,ANI,0,0,1, 0,0,fg,  "andi fetch"));
        tbl.push_back(mk(0,ANI,0,0,1, 1,0,dec, "andi decode"));
        tbl.push_back(mk(0,ANI,0,0,1, 9,0,ean, "andi exec_i"));
        tbl.push_back(mk(0,ANI,0,0,1, 10,0,eiz,"andi imm_wb"));
        tbl.push_back(mk(0,ADI,0,0,1, 0,0,fg,  "addi fetch"));
        tbl.push_back(mk(0,ADI,0,0,1, 1,0,dec, "addi decode"));
        tbl.push_back(mk(0,ADI,0,0,1, 9,0,ead, "addi exec_i"));
        tbl.push_back(mk(0,ADI,0,0,1, 10,0,iw, "addi imm_wb"));
        tbl.push_back(mk(0,SW,0,0,1,  0,0,fg,  "sw fetch"));
        tbl.push_back(mk(0,SW,0,0,1,  1,0,dec, "sw decode"));
        tbl.push_back(mk(0,SW,0,0,1,  2,0,mad, "sw mem_addr"));
        tbl.push_back(mk(0,SW,0,0,1,  5,0,mwr, "sw mem_write"));
        tbl.push_back(mk(0,J,0,0,1,   0,0,fg,  "j fetch"));
        tbl.push_back(mk(0,J,0,0,1,   1,0,dec, "j decode"));
        tbl.push_back(mk(0,J,0,0,1,   11,0,jmp,"j jump"));
        tbl.push_back(mk(0,ORI,0,0,0, 0,0,fw,  "ori fetch stall"));
        tbl.push_back(mk(0,ORI,0,0,1, 0,0,fg,  "ori fetch"));
        tbl.push_back(mk(0,ORI,0,0,1, 1,0,dec, "ori decode"));
        tbl.push_back(mk(0,R,0,0,1,   9,0,eor, "ori uses latched op"));
        tbl.push_back(mk(0,ORI,0,0,1, 10,0,eiz,"ori imm_wb"));
        tbl.push_back(mk(0,R,0,0,1,   0,0,fg,  "badfn fetch"));
        tbl.push_back(mk(0,R,0,0,1,   1,0,dec, "badfn decode"));
        tbl.push_back(mk(0,R,0,0,1,   12,2,z0, "badfn halt"));
        tbl.push_back(mk(0,R,ADD,0,0, 12,2,z0, "badfn sticky"));
        tbl.push_back(mk(1,R,ADD,0,1, 12,2,z0, "badfn reset cycle"));
        tbl.push_back(mk(0,R,ADD,0,1, 0,0,fg,  "badfn after reset"));

        @(negedge clk);
        foreach (tbl[i]) step(tbl[i]);

        // Bad opcode: stuck in HALT regardless of inputs until reset.
        step(mk(0,6'h3f,0,0,1, 1,0,dec, "badop decode"));
        for (int k = 0; k < 5; k++)
            step(mk(0,6'h3f,6'(k),k[0],k[1], 12,1,z0, "badop sticky"));
        step(mk(1,R,ADD,0,1, 12,1,z0, "badop reset cycle"));
        step(mk(0,R,ADD,0,0, 0,0,fw,  "badop after reset"));

        // Fetch timeout: four stalled fetches, then HALT with no IR load.
        for (int k = 0; k < 3; k++)
            step(mk(0,R,ADD,0,0, 0,0,fw, "fetch stall"));
        step(mk(0,R,ADD,0,0, 12,3,z0, "fetch timeout halt"));
        step(mk(0,R,ADD,0,1, 12,3,z0, "timeout sticky"));
        step(mk(1,R,ADD,0,1, 12,3,z0, "timeout reset cycle"));

        // Store that never completes.
        step(mk(0,SW,0,0,1, 0,0,fg,  "sw2 fetch"));
        step(mk(0,SW,0,0,1, 1,0,dec, "sw2 decode"));
        step(mk(0,SW,0,0,1, 2,0,mad, "sw2 mem_addr"));
        for (int k = 0; k < 4; k++)
            step(mk(0,SW,0,0,0, 5,0,mwr, "sw2 wait"));
        step(mk(0,SW,0,0,1, 12,3,z0, "sw write timeout"));
        step(mk(1,R,ADD,0,1, 12,3,z0, "sw2 reset cycle"));

        // Reset during writeback suppresses the register write.
        step(mk(0,R,ADD,0,1, 0,0,fg,  "add fetch"));
        step(mk(0,R,ADD,0,1, 1,0,dec, "add decode"));
        step(mk(0,R,ADD,0,1, 6,0,exa, "add execute"));
        step(mk(1,R,ADD,0,1, 7,0,z0,  "reset in alu_wb"));
        step(mk(0,R,ADD,0,1, 0,0,fg,  "fetch after reset"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
